imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: holds the PC, drives a zero-latency instruction
// memory and registers each returned word into a single fetch slot toward decode.
module imem_fetch_ctrl #(
  parameter int unsigned            INS_ADDRESS = 9,
  parameter int unsigned            INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   halt_req,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INS_W-1:0]       out_inst,
  output logic [INS_ADDRESS-1:0] out_pc,
  output logic                   busy,
  output logic                   misalign_err,
  output logic [15:0]            fetch_count,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_HALTED  = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [INS_ADDRESS-1:0] PC_STEP = INS_ADDRESS'(4);

  state_t                   state_q, state_d;
  logic [INS_ADDRESS-1:0]   pc_q, pc_d;
  logic                     valid_q, valid_d;
  logic [INS_W-1:0]         inst_q, inst_d;
  logic [INS_ADDRESS-1:0]   opc_q, opc_d;
  logic                     err_q, err_d;
  logic [15:0]              cnt_q, cnt_d;

  logic handshake;
  logic slot_free;
  logic misaligned;

  // Handshake: the slot transfers to decode on every cycle with out_valid && out_ready.
  // out_valid stays high and out_inst/out_pc stay stable until that transfer, unless
  // a redirect or a fault flushes the slot.
  assign handshake  = valid_q && out_ready;
  assign slot_free  = !valid_q || out_ready;
  assign misaligned = redirect_pc[1:0] != 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      inst_q  <= '0;
      opc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    // A consumed slot empties unless refilled below.
    valid_d = valid_q && !out_ready;
    inst_d  = inst_q;
    opc_d   = opc_q;
    err_d   = err_q;
    cnt_d   = (handshake && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid && misaligned) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          if (halt_req) state_d = ST_HALTED;
        end else if (halt_req) begin
          state_d = ST_DRAIN;
        end else if (slot_free) begin
          inst_d  = imem_rd;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_STEP;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid && misaligned) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = ST_HALTED;
        end else if (!valid_q || handshake) begin
          valid_d = 1'b0;
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        valid_d = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_ERROR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_ra      = pc_q;
  assign out_valid    = valid_q;
  assign out_inst     = inst_q;
  assign out_pc       = opc_q;
  assign busy         = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign misalign_err = err_q;
  assign fetch_count  = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model and an accepted-instruction queue.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic [8:0]  imem_ra;
  logic [31:0] imem_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [8:0]  out_pc;
  logic        busy;
  logic        misalign_err;
  logic [15:0] fetch_count;
  logic [2:0]  dbg_state;

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;

  imem_fetch_ctrl #(.INS_ADDRESS(9), .INS_W(32), .RESET_PC(9'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ra(imem_ra), .imem_rd(imem_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .busy(busy),
    .misalign_err(misalign_err), .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  assign imem_rd = mem[imem_ra[8:2]];

  // Behavioural reference model
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_DRAIN = 2, MD_HALT = 3, MD_ERR = 4;
  int          m_mode;
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_inst;
  int          m_opc;
  bit          m_err;
  int          m_cnt;
  logic [40:0] exp_q[$];

  function automatic void model_reset();
    m_mode = MD_IDLE; m_pc = 0; m_valid = 0; m_inst = '0; m_opc = 0; m_err = 0; m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step();
    bit hs;
    bit bad;
    hs  = m_valid && out_ready;
    bad = (int'(redirect_pc) % 4) != 0;
    if (hs) begin
      exp_q.push_back({9'(m_opc), m_inst});
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    case (m_mode)
      MD_IDLE: if (start) m_mode = MD_RUN;
      MD_RUN: begin
        if (redirect_valid && bad) begin
          m_mode = MD_ERR; m_err = 1; m_valid = 0;
        end else if (redirect_valid) begin
          m_pc = int'(redirect_pc); m_valid = 0;
          if (halt_req) m_mode = MD_HALT;
        end else if (halt_req) begin
          m_mode = MD_DRAIN;
          if (hs) m_valid = 0;
        end else if (!m_valid || out_ready) begin
          m_inst = mem[m_pc / 4]; m_opc = m_pc; m_valid = 1;
          m_pc = (m_pc + 4) % 512;
        end
      end
      MD_DRAIN: begin
        if (redirect_valid && bad) begin
          m_mode = MD_ERR; m_err = 1; m_valid = 0;
        end else if (redirect_valid) begin
          m_pc = int'(redirect_pc); m_valid = 0; m_mode = MD_HALT;
        end else if (!m_valid || hs) begin
          m_valid = 0; m_mode = MD_HALT;
        end
      end
      MD_HALT: begin
        m_valid = 0;
        if (start) m_mode = MD_RUN;
      end
      default: m_valid = 0;
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic load_program();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013 + (i << 20);
    mem[0] = 32'h0000_7033; mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113; mem[3] = 32'h0020_8433;
    mem[4] = 32'hCAFE_0010; mem[127] = 32'h1FC0_0001;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h want=0", out_inst); end
    checks++; if (out_pc !== 9'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", out_pc); end
    checks++; if (imem_ra !== 9'h0) begin errors++; $display("FAIL reset_ra got=%h want=0", imem_ra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", misalign_err); end
    checks++; if (fetch_count !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", fetch_count); end
    // Asynchronous reset in the middle of a cycle while fetching
    out_ready = 1; start = 1; tick(); start = 0; tick(); tick();
    #2 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_ra !== 9'h0 || fetch_count !== 16'h0 || busy !== 1'b0)
      begin errors++; $display("FAIL async_reset got v=%b ra=%h cnt=%0d busy=%b want 0,0,0,0", out_valid, imem_ra, fetch_count, busy); end
    do_reset();
  endtask

  task automatic test_sequence();
    logic [31:0] words [4];
    words[0] = 32'h0000_7033; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113; words[3] = 32'h0020_8433;
    do_reset();
    out_ready = 1; start = 1; tick(); start = 0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL seq_start got v=%b busy=%b want 0,1", out_valid, busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_inst !== words[i] || out_pc !== 9'(4 * i))
        begin errors++; $display("FAIL seq_word%0d got v=%b inst=%h pc=%h want 1 %h %h", i, out_valid, out_inst, out_pc, words[i], 9'(4 * i)); end
    end
    tick();
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count got=%0d want=4", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 0; start = 1; tick(); start = 0; tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0000_7033 || out_pc !== 9'h0 || imem_ra !== 9'h4)
        begin errors++; $display("FAIL stall_hold%0d got v=%b inst=%h pc=%h ra=%h want 1 00007033 000 004", i, out_valid, out_inst, out_pc, imem_ra); end
    end
    out_ready = 1; tick();
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_0093 || out_pc !== 9'h4 || fetch_count !== 16'd1)
      begin errors++; $display("FAIL stall_release got v=%b inst=%h pc=%h cnt=%0d want 1 00100093 004 1", out_valid, out_inst, out_pc, fetch_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 0; start = 1; tick(); start = 0; tick();
    redirect_valid = 1; redirect_pc = 9'h010; tick(); redirect_valid = 0;
    checks++; if (out_valid !== 1'b0 || imem_ra !== 9'h010 || fetch_count !== 16'd0)
      begin errors++; $display("FAIL redirect_flush got v=%b ra=%h cnt=%0d want 0 010 0", out_valid, imem_ra, fetch_count); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 9'h010 || out_inst !== 32'hCAFE_0010 || imem_ra !== 9'h014)
      begin errors++; $display("FAIL redirect_capture got v=%b pc=%h inst=%h ra=%h want 1 010 cafe0010 014", out_valid, out_pc, out_inst, imem_ra); end
  endtask

  task automatic test_halt_drain();
    do_reset();
    out_ready = 0; start = 1; tick(); start = 0; tick();
    halt_req = 1; tick(); halt_req = 0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_enter got busy=%b v=%b want 1,1", busy, out_valid); end
    tick();
    checks++; if (busy !== 1'b1 || out_inst !== 32'h0000_7033) begin errors++; $display("FAIL drain_hold got busy=%b inst=%h want 1 00007033", busy, out_inst); end
    out_ready = 1; tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || fetch_count !== 16'd1 || imem_ra !== 9'h4)
      begin errors++; $display("FAIL drain_done got busy=%b v=%b cnt=%0d ra=%h want 0 0 1 004", busy, out_valid, fetch_count, imem_ra); end
    tick();
    checks++; if (busy !== 1'b0 || imem_ra !== 9'h4) begin errors++; $display("FAIL halted_hold got busy=%b ra=%h want 0 004", busy, imem_ra); end
    start = 1; tick(); start = 0; tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 9'h4 || out_inst !== 32'h0010_0093)
      begin errors++; $display("FAIL resume got v=%b pc=%h inst=%h want 1 004 00100093", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_misalign();
    do_reset();
    out_ready = 1; start = 1; tick(); start = 0; tick();
    redirect_valid = 1; redirect_pc = 9'h006; tick(); redirect_valid = 0;
    checks++; if (misalign_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || imem_ra !== 9'h4)
      begin errors++; $display("FAIL misalign_enter got err=%b v=%b busy=%b ra=%h want 1 0 0 004", misalign_err, out_valid, busy, imem_ra); end
    start = 1; redirect_valid = 1; redirect_pc = 9'h020; tick(); tick(); start = 0; redirect_valid = 0;
    checks++; if (misalign_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || imem_ra !== 9'h4)
      begin errors++; $display("FAIL misalign_sticky got err=%b v=%b busy=%b ra=%h want 1 0 0 004", misalign_err, out_valid, busy, imem_ra); end
    do_reset();
    checks++; if (misalign_err !== 1'b0 || imem_ra !== 9'h0 || busy !== 1'b0)
      begin errors++; $display("FAIL misalign_clear got err=%b ra=%h busy=%b want 0 000 0", misalign_err, imem_ra, busy); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1; start = 1; tick(); start = 0;
    redirect_valid = 1; redirect_pc = 9'h1FC; tick(); redirect_valid = 0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 9'h1FC || out_inst !== 32'h1FC0_0001 || imem_ra !== 9'h000)
      begin errors++; $display("FAIL wrap got v=%b pc=%h inst=%h ra=%h want 1 1fc 1fc00001 000", out_valid, out_pc, out_inst, imem_ra); end
    halt_req = 1; redirect_valid = 1; redirect_pc = 9'h020; tick(); halt_req = 0; redirect_valid = 0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || imem_ra !== 9'h020)
      begin errors++; $display("FAIL halt_redirect got busy=%b v=%b ra=%h want 0 0 020", busy, out_valid, imem_ra); end
    redirect_valid = 1; redirect_pc = 9'h040; tick(); redirect_valid = 0;
    checks++; if (imem_ra !== 9'h020 || busy !== 1'b0) begin errors++; $display("FAIL halted_ignore got ra=%h busy=%b want 020 0", imem_ra, busy); end
  endtask

  task automatic test_random();
    bit          hs;
    logic [40:0] seen;
    logic [40:0] want;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_mode == MD_ERR && $urandom_range(0, 7) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      start          = ($urandom_range(0, 3) == 0);
      halt_req       = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 9'($urandom_range(0, 127) * 4);
      if ($urandom_range(0, 39) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      out_ready      = ($urandom_range(0, 2) != 0);
      hs   = out_valid && out_ready;
      seen = {out_pc, out_inst};
      tick();
      if (hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_accept_extra cyc=%0d got=%h want=none", cyc, seen);
        end else begin
          want = exp_q.pop_front();
          if (seen !== want) begin errors++; $display("FAIL rand_accept cyc=%0d got=%h want=%h", cyc, seen, want); end
        end
      end
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", cyc, out_valid, m_valid); end
      checks++; if (out_inst !== m_inst) begin errors++; $display("FAIL rand_inst cyc=%0d got=%h want=%h", cyc, out_inst, m_inst); end
      checks++; if (out_pc !== 9'(m_opc)) begin errors++; $display("FAIL rand_opc cyc=%0d got=%h want=%h", cyc, out_pc, 9'(m_opc)); end
      checks++; if (imem_ra !== 9'(m_pc)) begin errors++; $display("FAIL rand_ra cyc=%0d got=%h want=%h", cyc, imem_ra, 9'(m_pc)); end
      checks++; if (busy !== (m_mode == MD_RUN || m_mode == MD_DRAIN)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b mode=%0d", cyc, busy, m_mode); end
      checks++; if (misalign_err !== m_err) begin errors++; $display("FAIL rand_err cyc=%0d got=%b want=%b", cyc, misalign_err, m_err); end
      checks++; if (fetch_count !== 16'(m_cnt)) begin errors++; $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", cyc, fetch_count, m_cnt); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_accept_missing cyc=%0d pending=%0d want=0", cyc, exp_q.size()); exp_q.delete(); end
    end
  endtask

  initial begin
    load_program();
    model_reset();
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_halt_drain();
    test_misalign();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
